// File: rtl/gated_register_pkg.sv
// Shared constants and data-word type for gated_register and the datapaths that instantiate it.
package gated_register_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VALUE = '0;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage : gated_register_pkg

// File: rtl/gated_register_parity_calc.sv
// Combinational even-parity (XOR reduction) of a WIDTH-bit word.
module gated_register_parity_calc
  import gated_register_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_c
);

  assign parity_c = ^data_i;

endmodule : gated_register_parity_calc

// File: rtl/gated_register.sv
// Load-enable storage register with asynchronous active-high clear.
// Optional stored parity bit (port Rpar) under GATED_REGISTER_PARITY_EN.
module gated_register
  import gated_register_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] Rin,
  output logic [WIDTH-1:0] Rout
`ifdef GATED_REGISTER_PARITY_EN
  ,
  output logic             Rpar
`endif
);

  logic [WIDTH-1:0] rout_d;
  logic [WIDTH-1:0] rout_q;

  always_comb begin
    rout_d = rout_q;
    if (en) begin
      rout_d = Rin;
    end
  end

  // Reset branch first so an X/Z enable or data cannot disturb the cleared value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rout_q <= RESET_VALUE;
    end else begin
      rout_q <= rout_d;
    end
  end

  assign Rout = rout_q;

`ifdef GATED_REGISTER_PARITY_EN
  localparam logic RESET_PARITY = ^RESET_VALUE;

  logic rin_parity_c;
  logic rpar_d;
  logic rpar_q;

  gated_register_parity_calc #(
    .WIDTH (WIDTH)
  ) u_parity_calc (
    .data_i   (Rin),
    .parity_c (rin_parity_c)
  );

  always_comb begin
    rpar_d = rpar_q;
    if (en) begin
      rpar_d = rin_parity_c;
    end
  end

  // Shares enable, clear and edge with rout_q so Rpar always tracks ^Rout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpar_q <= RESET_PARITY;
    end else begin
      rpar_q <= rpar_d;
    end
  end

  assign Rpar = rpar_q;
`endif

endmodule : gated_register

// File: tb/tb_gated_register.sv
// Scoreboard bench for gated_register: default 8-bit, WIDTH=1 and WIDTH=32 instances.
// Checks Rpar too when GATED_REGISTER_PARITY_EN is defined.
module tb_gated_register;

  typedef struct {
    int          id;
    string       nm;
    logic [31:0] v;
  } exp_t;

  logic        tb_clk = 1'b0;
  logic        clk_on = 1'b0;
  logic        clk;
  logic        reset  = 1'b0;

  logic        en8    = 1'bx;
  logic [7:0]  rin8   = 8'hxx;
  logic [7:0]  rout8;
  logic        en1    = 1'b0;
  logic [0:0]  rin1   = 1'b0;
  logic [0:0]  rout1;
  logic        en32   = 1'b0;
  logic [31:0] rin32  = 32'h0;
  logic [31:0] rout32;
`ifdef GATED_REGISTER_PARITY_EN
  logic        rpar8;
  logic        rpar1;
  logic        rpar32;
`endif

  exp_t        sb[$];
  exp_t        e_m;
  logic [31:0] act_m;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 tb_clk = ~tb_clk;
  // DUT clock is gated so reset can be shown to act with no clock edge at all.
  assign clk = tb_clk & clk_on;

  gated_register u8 (
    .clk   (clk),
    .reset (reset),
    .en    (en8),
    .Rin   (rin8),
    .Rout  (rout8)
`ifdef GATED_REGISTER_PARITY_EN
    ,
    .Rpar  (rpar8)
`endif
  );

  gated_register #(
    .WIDTH (1)
  ) u1 (
    .clk   (clk),
    .reset (reset),
    .en    (en1),
    .Rin   (rin1),
    .Rout  (rout1)
`ifdef GATED_REGISTER_PARITY_EN
    ,
    .Rpar  (rpar1)
`endif
  );

  gated_register #(
    .WIDTH       (32),
    .RESET_VALUE (32'hA5A5_A5A5)
  ) u32 (
    .clk   (clk),
    .reset (reset),
    .en    (en32),
    .Rin   (rin32),
    .Rout  (rout32)
`ifdef GATED_REGISTER_PARITY_EN
    ,
    .Rpar  (rpar32)
`endif
  );

  function automatic logic [31:0] actual(input int id);
    logic [31:0] r;
    r = 32'hDEAD_BEEF;
    case (id)
      0: r = {24'h0, rout8};
      1: r = {31'h0, rout1};
      2: r = rout32;
`ifdef GATED_REGISTER_PARITY_EN
      3: r = {31'h0, rpar8};
      4: r = {31'h0, rpar32};
`endif
      default: r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  task automatic push_exp(input int id, input string nm, input logic [31:0] v);
    exp_t e;
    e.id = id;
    e.nm = nm;
    e.v  = v;
    sb.push_back(e);
  endtask

  task automatic push_par(input string nm, input logic p);
`ifdef GATED_REGISTER_PARITY_EN
    push_exp(3, nm, {31'h0, p});
`else
    if (p === 1'bz) push_exp(0, nm, 32'h0);
`endif
  endtask

  // Inputs change 1 time unit after a tb negedge; the response is checked at the next negedge.
  task automatic step();
    @(negedge tb_clk);
    #1;
  endtask

  // Monitor: drain every pending expectation on each tb negedge.
  always @(negedge tb_clk) begin
    while (sb.size() > 0) begin
      e_m   = sb.pop_front();
      act_m = actual(e_m.id);
      n_vec++;
      if (act_m !== e_m.v) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e_m.nm, act_m, e_m.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up: reset with the DUT clock idle and en/Rin unknown.
    #2;
    reset = 1'b1;
    push_exp(0, "por_rout8", 32'h0000_0000);
    push_exp(1, "por_rout1", 32'h0000_0000);
    push_exp(2, "por_rout32", 32'hA5A5_A5A5);
    push_par("por_rpar8", 1'b0);
`ifdef GATED_REGISTER_PARITY_EN
    push_exp(4, "por_rpar32", 32'h0000_0000);
`endif

    step();
    reset = 1'b0; clk_on = 1'b1;
    en8 = 1'b1; rin8 = 8'd1;
    en1 = 1'b1; rin1 = 1'b1;
    en32 = 1'b1; rin32 = 32'hFFFF_FFFF;
    push_exp(0, "load1", 32'd1);
    push_exp(1, "w1_load_one", 32'd1);
    push_exp(2, "w32_load_ones", 32'hFFFF_FFFF);
    push_par("par_load1", 1'b1);

    step();
    rin8 = 8'd2; rin1 = 1'b0; rin32 = 32'h0;
    push_exp(0, "load2", 32'd2);
    push_exp(1, "w1_load_zero", 32'd0);
    push_exp(2, "w32_load_zeros", 32'h0);
    push_par("par_load2", 1'b1);

    step();
    rin8 = 8'd3;
    en1 = 1'b0; rin1 = 1'b1;
    en32 = 1'b0; rin32 = 32'h1234_5678;
    push_exp(0, "load3", 32'd3);
    push_exp(1, "w1_hold", 32'd0);
    push_exp(2, "w32_hold", 32'h0);
    push_par("par_load3", 1'b0);

    for (int i = 0; i < 3; i++) begin
      step();
      en8 = 1'b0; rin8 = 8'd9;
      push_exp(0, $sformatf("hold%0d", i), 32'd3);
      push_par($sformatf("par_hold%0d", i), 1'b0);
    end

    // Mid-cycle reset with no clock edge before the check.
    step();
    clk_on = 1'b0; reset = 1'b1;
    push_exp(0, "mid_reset_rout8", 32'd0);
    push_exp(1, "mid_reset_rout1", 32'd0);
    push_exp(2, "mid_reset_rout32", 32'hA5A5_A5A5);
    push_par("par_mid_reset", 1'b0);

    step();
    reset = 1'b0; clk_on = 1'b1;
    en8 = 1'b1; rin8 = 8'd4;
    push_exp(0, "load4", 32'd4);
    push_par("par_load4", 1'b1);

    step();
    rin8 = 8'd5;
    push_exp(0, "load5", 32'd5);
    push_par("par_load5", 1'b0);

    // Reset held across a load-enabled edge: reset wins.
    step();
    reset = 1'b1; en8 = 1'b1; rin8 = 8'hFF;
    en32 = 1'b1; rin32 = 32'h0;
    push_exp(0, "reset_vs_load8", 32'd0);
    push_exp(2, "reset_vs_load32", 32'hA5A5_A5A5);
    push_par("par_reset_vs_load", 1'b0);

    step();
    en8 = 1'bx; rin8 = 8'hxx;
    push_exp(0, "reset_x_inputs", 32'd0);

    step();
    reset = 1'b0; en8 = 1'b0; rin8 = 8'hFF; en32 = 1'b0;
    push_exp(0, "release_hold", 32'd0);
    push_exp(2, "w32_release_hold", 32'hA5A5_A5A5);

    step();
    en8 = 1'b1; rin8 = 8'h80;
    push_exp(0, "first_load_after_release", 32'h80);
    push_par("par_first_load", 1'b1);

    for (int i = 0; i < 5 && sb.size() > 0; i++) begin
      @(negedge tb_clk);
      #1;
    end
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0 pending", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_gated_register

// File: doc/gated_register.md
# gated_register

Parameterised load-enable storage register with asynchronous active-high clear. On each rising clock edge it captures its data input when the enable is asserted and holds its value otherwise. It is the basic state-holding element for datapath operands, accumulator staging and pipeline holding stages. An optional stored parity bit can be compiled in.

## Interface
Parameters:
- WIDTH, default 8: data width in bits, at least 1.
- RESET_VALUE, default all zeros (WIDTH bits): value loaded by reset.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- reset  input  1  asynchronous, active-high reset. Sole reset of the block.
- en  input  1  load enable, sampled at the rising edge of clk.
- Rin  input  WIDTH  data to load.
- Rout  output  WIDTH  stored value, driven directly from the flops.
- Rpar  output  1  stored even-parity bit. Present only with GATED_REGISTER_PARITY_EN.

## Operation
- reset = 1: Rout is forced to RESET_VALUE immediately, without waiting for a clock edge. It stays there while reset is held, regardless of clk, en or Rin.
- reset = 0, rising edge of clk, en = 1: Rout takes the value of Rin.
- reset = 0, rising edge of clk, en = 0: Rout holds its value.
- If en or Rin is X or Z while reset = 1, Rout must still show RESET_VALUE.
- There is no handshake, no arithmetic and no wrap-around. This is a pure storage element.
- Rin must be presented as a full WIDTH-bit value; the block does not extend or truncate it.
- Reset at the same time as a load-enabled edge: reset wins.

## Timing
- Load latency is one clock edge: a Rin value present with en = 1 at edge N appears on Rout after edge N, within the clock-to-Q delay.
- Reset assertion takes effect asynchronously, within the flop's clear-to-Q delay, even in the middle of a clock cycle.
- Reset deassertion is asynchronous at the pin. The first load happens at the first rising edge after release.
- Integrators must release reset away from the clk rising edge, or synchronise the release upstream.
- Reset value of every output:
  - Rout = RESET_VALUE.
  - Rpar = XOR reduction of RESET_VALUE, which is 0 for the default.
- Rout is glitch-free between edges because it is driven straight from registers with no output logic.

## Configuration
- Macro: GATED_REGISTER_PARITY_EN.
- When defined:
  - The port Rpar exists.
  - One extra flop stores the XOR reduction of Rin and uses the same en, reset and edge as Rout.
  - Rpar therefore always equals the XOR reduction of Rout.
- When undefined: the port Rpar and its flop do not exist, and the behaviour of Rout is identical.

## Structure
- Shared package gated_register_pkg holds:
  - the default width constant (8);
  - the default reset-value constant;
  - a typedef for the WIDTH-wide data word, used by instantiating datapaths.
- One natural sub-module is parity_calc: a combinational XOR reduction of a WIDTH-bit word. It is instantiated only under GATED_REGISTER_PARITY_EN.
- The top level contains a single always-block register with async clear, plus the optional parity flop.

## Test plan
- Power-up: assert reset = 1 with clk idle and en = X -> Rout = 8'd0 with no clock edge.
- Release reset, set en = 1, and apply Rin = 8'd1, 8'd2, 8'd3 on successive edges -> Rout = 1, 2, 3, each one edge later. With parity enabled, Rpar = 1, 1, 0.
- Hold: Rout = 8'd3, en = 0, Rin = 8'd9 for 3 edges -> Rout stays 8'd3.
- Mid-cycle reset: Rout = 8'd3, pulse reset = 1 while clk is low -> Rout = 0 immediately. Release, load Rin = 8'd4, then 8'd5 -> Rout = 4, then 5.
- Simultaneous events: reset = 1 across a rising edge with en = 1 and Rin = 8'hFF -> Rout stays 0.
- Parameter sweep: WIDTH = 1 and WIDTH = 32 with RESET_VALUE = 32'hA5A5_A5A5 -> reset gives A5A5_A5A5, and loads of all-ones and all-zeros are exact.
